// File: rtl/fetch_unit.sv
// fetch_unit: PC, bounded outstanding instruction reads and a small instruction FIFO toward decode.
// Optional macro FETCH_PERF_EN adds the perf_fetched / perf_stall counter ports.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                BUF_DEPTH = 2,
  parameter int                MAX_OUT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = 3;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [OW-1:0]     r_out, r_drop;
  logic [OW-1:0]     w_out_next, w_drop_next, w_live;
  logic [SW-1:0]     w_used;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [31:0]       r_mem_data [BUF_DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [BUF_DEPTH];
  logic [ADDR_W-1:0] w_tag;
  logic              w_accept, w_push, w_pop, w_drop_rsp;

  // Live reads are sequential and end at pc-4, so the oldest one belongs to pc - 4*outstanding.
  always_comb begin
    w_live         = r_out - r_drop;
    w_used         = SW'(r_count) + SW'(w_live);
    imem_req_valid = fetch_en & (r_state != S_IDLE) & ~br_taken &
                     (r_out < OW'(MAX_OUT)) & (w_used < SW'(BUF_DEPTH));
    w_accept       = imem_req_valid & imem_req_ready;
    w_drop_rsp     = imem_rsp_valid & (r_drop != {OW{1'b0}});
    w_push         = imem_rsp_valid & (r_drop == {OW{1'b0}}) & ~br_taken;
    w_pop          = instr_valid & instr_ready;
    w_out_next     = r_out + OW'(w_accept) - OW'(imem_rsp_valid);
    w_drop_next    = br_taken ? w_out_next : (r_drop - OW'(w_drop_rsp));
    w_tag          = r_pc - (ADDR_W'(r_out) << 2);
  end

  // Next-state logic: redirect with reads in flight enters FLUSH until all are drained.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_RUN;
      S_RUN, S_FLUSH: begin
        if (br_taken) begin
          w_state_next = (w_out_next != {OW{1'b0}}) ? S_FLUSH : S_RUN;
        end else if ((r_state == S_FLUSH) && (w_drop_next == {OW{1'b0}})) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = r_state;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, PC, outstanding and stale-read counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_out   <= {OW{1'b0}};
      r_drop  <= {OW{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_drop  <= w_drop_next;
      if (br_taken) begin
        r_pc <= br_target & {{(ADDR_W-2){1'b1}}, 2'b00};
      end else if (w_accept) begin
        r_pc <= r_pc + ADDR_W'(32'd4);
      end else begin
        r_pc <= r_pc;
      end
    end
  end

  // Instruction FIFO; a redirect empties it in the same cycle it discards any response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem_data[i] <= 32'd0;
        r_mem_pc[i]   <= {ADDR_W{1'b0}};
      end
    end else if (br_taken) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= imem_rsp_data;
        r_mem_pc[r_wr_ptr]   <= w_tag;
        r_wr_ptr             <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign imem_req_addr = r_pc;
  assign instr_valid   = (r_count != {CW{1'b0}});
  assign instr         = r_mem_data[r_rd_ptr];
  assign instr_pc      = r_mem_pc[r_rd_ptr];

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  // Pop count and decode-starved cycles, both free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (instr_ready & ~instr_valid & (r_state != S_IDLE)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  fetch_unit_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .MAX_OUT   (MAX_OUT),
    .CW        (CW),
    .OW        (OW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (w_push),
    .pop         (w_pop),
    .count       (r_count),
    .outstanding (r_out),
    .drop        (r_drop)
  );
endmodule

// fetch_unit_chk: structural invariants of the fetch FIFO and read accounting.
module fetch_unit_chk #(
  parameter int BUF_DEPTH = 2,
  parameter int MAX_OUT   = 2,
  parameter int CW        = 2,
  parameter int OW        = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count,
  input logic [OW-1:0] outstanding,
  input logic [OW-1:0] drop
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(BUF_DEPTH))));
  a_out_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= OW'(MAX_OUT));
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop <= outstanding);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench; the model expects the sequential address stream
// since the last redirect, with data from a fixed-latency in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          BD  = 2;
  localparam int          MO  = 2;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, fetch_en, br_taken, imem_req_ready, instr_ready;
  logic [31:0] br_target;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_unit #(.ADDR_W(32), .RESET_PC(RPC), .BUF_DEPTH(BD), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .br_taken(br_taken), .br_target(br_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rd_t;

  rd_t         pend[$];     // reads accepted by memory, not yet answered
  logic [31:0] exp_q[$];    // pcs the decoder must still receive, oldest first
  int          lat = 1;
  int          pops = 0, stalls = 0, post = 0;
  int          first_acc = -1, first_vld = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers each accepted read exactly lat cycles later, in order.
  initial begin
    rd_t rd;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        rd             = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rd.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Issue side: checks request addresses, records expected words, applies redirects.
  initial begin
    logic [31:0] issue_pc, redir_addr;
    bit          chk_redir;
    issue_pc   = RPC;
    redir_addr = 32'd0;
    chk_redir  = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        exp_q.delete();
        pend.delete();
        issue_pc  = RPC;
        chk_redir = 1'b0;
        first_acc = -1;
      end else begin
        if (chk_redir) begin
          chk(instr_valid == 1'b0, "redirect_empty", 32'(instr_valid), 32'd0);
          chk(imem_req_addr == redir_addr, "redirect_addr", imem_req_addr, redir_addr);
          chk_redir = 1'b0;
        end
        if (!fetch_en) chk(imem_req_valid == 1'b0, "fetch_disabled", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
          chk(imem_req_addr == issue_pc, "req_addr", imem_req_addr, issue_pc);
          pend.push_back('{due: cyc + lat, addr: imem_req_addr});
          exp_q.push_back(issue_pc);
          issue_pc = issue_pc + 32'd4;
          chk(exp_q.size() <= BD, "fifo_credit", 32'(exp_q.size()), 32'(BD));
          chk(pend.size() <= MO, "max_outstanding", 32'(pend.size()), 32'(MO));
          if (first_acc < 0) first_acc = cyc;
        end
        if (br_taken) begin
          exp_q.delete();
          issue_pc   = br_target & 32'hFFFF_FFFC;
          redir_addr = issue_pc;
          chk_redir  = 1'b1;
        end
      end
    end
  end

  // Monitor: every pop must be the next expected word; also tallies pops and starved cycles.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        post = 0; pops = 0; stalls = 0; first_vld = -1;
      end else begin
        if (instr_valid && first_vld < 0) first_vld = cyc;
        if (post > 0 && instr_ready && !instr_valid) stalls++;
        post++;
        if (instr_valid && instr_ready) begin
          pops++;
          chk(exp_q.size() > 0, "pop_expected", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(instr_pc == e, "instr_pc", instr_pc, e);
            chk(instr == mem_word(e), "instr_data", instr, mem_word(e));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drain();
    fetch_en = 1'b0;
    br_taken = 1'b0;
    for (int i = 0; i < 40 && pend.size() > 0; i++) step(1);
    chk(pend.size() == 0, "drain", 32'(pend.size()), 32'd0);
    step(2);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_taken  = 1'b1;
    br_target = tgt;
    step(1);
    br_taken  = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      br_taken       = ($urandom_range(0, 19) == 0);
      br_target      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      step(1);
    end
    br_taken       = 1'b0;
    imem_req_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    step(3);
    chk(imem_req_valid == 1'b0, "rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk(imem_req_addr == RPC, "rst_req_addr", imem_req_addr, RPC);
    chk(instr_valid == 1'b0, "rst_instr_valid", 32'(instr_valid), 32'd0);
    chk(instr == 32'd0, "rst_instr", instr, 32'd0);
    chk(instr_pc == 32'd0, "rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk(perf_fetched == 32'd0, "rst_perf_fetched", perf_fetched, 32'd0);
    chk(perf_stall == 32'd0, "rst_perf_stall", perf_stall, 32'd0);
`endif
    // Streaming from RESET_PC with a one-cycle memory.
    rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    step(20);
    chk(first_acc >= 0 && (first_vld - first_acc) == 2, "first_latency",
        32'(first_vld - first_acc), 32'd2);

    // Decode back-pressure: buffer fills, requests stop, then drains in order.
    instr_ready = 1'b0;
    step(10);
    chk(imem_req_valid == 1'b0, "stall_no_req", 32'(imem_req_valid), 32'd0);
    chk(instr_valid == 1'b1, "stall_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    step(10);

    // Three-cycle memory, redirect with two reads in flight to an unaligned target.
    drain();
    lat = 3; fetch_en = 1'b1;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step(1);
    chk(pend.size() == 2, "two_in_flight", 32'(pend.size()), 32'd2);
    redirect(32'h0000_2002);
    for (int i = 0; i < 20 && !instr_valid; i++) step(1);
    chk(instr_pc == 32'h0000_2000, "first_after_redirect", instr_pc, 32'h0000_2000);
    step(10);

    // One-cycle memory: redirect while a response is arriving.
    drain();
    lat = 1; fetch_en = 1'b1;
    step(6);
    redirect(32'h0000_3000);
    step(8);

    // PC wrap at the top of the address space, then fetch disabled while draining.
    redirect(32'hFFFF_FFFC);
    step(1);
    chk(imem_req_addr == 32'd0, "pc_wrap", imem_req_addr, 32'd0);
    step(6);
    fetch_en = 1'b0; instr_ready = 1'b0;
    step(4);
    instr_ready = 1'b1;
    step(6);
    chk(instr_valid == 1'b0, "fetch_off_drained", 32'(instr_valid), 32'd0);

    // Randomized traffic at two memory latencies.
    drain(); lat = 2; random_run(1500);
    drain(); lat = 1; random_run(1500);
    drain();

`ifdef FETCH_PERF_EN
    instr_ready = 1'b0;
    rst = 1'b1; step(2);
    rst = 1'b0; fetch_en = 1'b0;
    step(2);
    instr_ready = 1'b1;
    step(3);
    instr_ready = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 60 && pops < 5; i++) begin
      instr_ready = instr_valid;
      step(1);
    end
    instr_ready = 1'b0; fetch_en = 1'b0;
    step(1);
    chk(perf_fetched == 32'd5 && perf_fetched == 32'(pops), "perf_fetched", perf_fetched, 32'd5);
    chk(perf_stall == 32'd3 && perf_stall == 32'(stalls), "perf_stall", perf_stall, 32'd3);
    drain();
    rst = 1'b1; step(1);
    chk(perf_fetched == 32'd0, "perf_fetched_rst", perf_fetched, 32'd0);
    chk(perf_stall == 32'd0, "perf_stall_rst", perf_stall, 32'd0);
    rst = 1'b0; step(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
endmodule
